eeprom_burst_ctrl: RTL and testbench

- Parametrised multi-byte EEPROM access controller.
- Accepts one command: read or write, start address, length 1..MAX_LEN bytes. Expands it into a sequence of single-byte random reads or byte writes on the existing byte-level I2C master request/ack interface, incrementing and wrapping the address itself.
- Streams data through valid/ready ports.
- Enforces the power-up delay and the per-byte EEPROM write-cycle time.
- Reports completion and bus errors.
- Sits between game logic (score/save storage) and the shared I2C master.

---
 rtl/eeprom_burst_ctrl_if.sv | 46 ++++
 rtl/eeprom_burst_ctrl.sv | 158 +++++++++++++++
 tb/tb_eeprom_burst_ctrl.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eeprom_burst_ctrl_if.sv
// Bundle of command, data-stream and I2C-master request/ack signals for eeprom_burst_ctrl.
// slave = controller view, master = the surrounding logic (game side plus I2C master).
interface eeprom_burst_ctrl_if #(
   parameter int MAX_LEN = 64
);
   localparam int LEN_W = $clog2(MAX_LEN + 1);

   logic             cmd_valid;
   logic             cmd_ready;
   logic             cmd_write;
   logic [15:0]      cmd_addr;
   logic [LEN_W-1:0] cmd_len;
   logic             wr_valid;
   logic             wr_ready;
   logic [7:0]       wr_data;
   logic             rd_valid;
   logic             rd_ready;
   logic [7:0]       rd_data;
   logic             busy;
   logic             done;
   logic             error;
   logic             m_read_req;
   logic             m_write_req;
   logic             m_read_ack;
   logic             m_write_ack;
   logic [7:0]       m_dev_addr;
   logic [15:0]      m_reg_addr;
   logic [7:0]       m_wdata;
   logic [7:0]       m_rdata;
   logic             m_error;
   logic             m_addr_2byte;

   modport slave (
      input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
             m_read_ack, m_write_ack, m_rdata, m_error,
      output cmd_ready, wr_ready, rd_valid, rd_data, busy, done, error,
             m_read_req, m_write_req, m_dev_addr, m_reg_addr, m_wdata, m_addr_2byte
   );

   modport master (
      output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
             m_read_ack, m_write_ack, m_rdata, m_error,
      input  cmd_ready, wr_ready, rd_valid, rd_data, busy, done, error,
             m_read_req, m_write_req, m_dev_addr, m_reg_addr, m_wdata, m_addr_2byte
   );
endinterface

// File: rtl/eeprom_burst_ctrl.sv
// Multi-byte EEPROM access controller: expands one burst command into single-byte
// random reads / byte writes on a shared I2C master, with power-up and tWR delays.
module eeprom_burst_ctrl #(
   parameter logic [7:0] DEV_ADDR       = 8'hA0,
   parameter bit         ADDR_2BYTE     = 1'b1,
   parameter int         MEM_BYTES      = 8192,
   parameter int         MAX_LEN        = 64,
   parameter int         POWERUP_CYCLES = 12_500_000,
   parameter int         WRCYC_CYCLES   = 250_000
) (
   input logic               clk,
   input logic               rst_n,
   eeprom_burst_ctrl_if.slave bus
);
   localparam int               LEN_W     = $clog2(MAX_LEN + 1);
   localparam logic [15:0]      ADDR_MASK = 16'(MEM_BYTES - 1);
   localparam logic [31:0]      PU_LAST   = 32'(POWERUP_CYCLES - 1);
   localparam logic [31:0]      WR_LAST   = 32'(WRCYC_CYCLES - 1);
   localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

   typedef enum logic [2:0] {
      S_POWERUP, S_IDLE, S_RD_REQ, S_RD_OUT, S_WR_FETCH, S_WR_REQ, S_WR_WAIT, S_DONE
   } state_t;

   state_t           state_reg, state_next;
   logic [31:0]      cnt_reg, cnt_next;
   logic [15:0]      addr_reg, addr_next;
   logic [LEN_W-1:0] rem_reg, rem_next;
   logic [7:0]       rd_data_reg, rd_data_next;
   logic [7:0]       wdata_reg, wdata_next;
   logic             error_reg, error_next;
   logic [15:0]      addr_inc;

   assign addr_inc = (addr_reg + 16'd1) & ADDR_MASK;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= S_POWERUP;
         cnt_reg     <= '0;
         addr_reg    <= '0;
         rem_reg     <= '0;
         rd_data_reg <= '0;
         wdata_reg   <= '0;
         error_reg   <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         addr_reg    <= addr_next;
         rem_reg     <= rem_next;
         rd_data_reg <= rd_data_next;
         wdata_reg   <= wdata_next;
         error_reg   <= error_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      addr_next    = addr_reg;
      rem_next     = rem_reg;
      rd_data_next = rd_data_reg;
      wdata_next   = wdata_reg;
      error_next   = error_reg;
      case (state_reg)
         S_POWERUP: begin
            if (cnt_reg == PU_LAST) begin
               cnt_next   = '0;
               state_next = S_IDLE;
            end else begin
               cnt_next = cnt_reg + 32'd1;
            end
         end
         S_IDLE: begin
            if (bus.cmd_valid) begin
               addr_next  = bus.cmd_addr & ADDR_MASK;
               rem_next   = bus.cmd_len;
               error_next = 1'b0;
               // Illegal lengths finish immediately without touching the bus.
               if (bus.cmd_len == '0 || bus.cmd_len > LEN_MAX) begin
                  error_next = 1'b1;
                  state_next = S_DONE;
               end else if (bus.cmd_write) begin
                  state_next = S_WR_FETCH;
               end else begin
                  state_next = S_RD_REQ;
               end
            end
         end
         S_RD_REQ: begin
            if (bus.m_read_ack) begin
               rd_data_next = bus.m_rdata;
               if (bus.m_error) begin
                  error_next = 1'b1;
                  state_next = S_DONE;
               end else begin
                  state_next = S_RD_OUT;
               end
            end
         end
         S_RD_OUT: begin
            if (bus.rd_ready) begin
               addr_next  = addr_inc;
               rem_next   = rem_reg - LEN_ONE;
               state_next = (rem_reg == LEN_ONE) ? S_DONE : S_RD_REQ;
            end
         end
         S_WR_FETCH: begin
            if (bus.wr_valid) begin
               wdata_next = bus.wr_data;
               state_next = S_WR_REQ;
            end
         end
         S_WR_REQ: begin
            if (bus.m_write_ack) begin
               if (bus.m_error) begin
                  error_next = 1'b1;
                  state_next = S_DONE;
               end else begin
                  cnt_next   = '0;
                  state_next = S_WR_WAIT;
               end
            end
         end
         S_WR_WAIT: begin
            // The final byte waits too, so done implies the data is committed.
            if (cnt_reg == WR_LAST) begin
               cnt_next   = '0;
               addr_next  = addr_inc;
               rem_next   = rem_reg - LEN_ONE;
               state_next = (rem_reg == LEN_ONE) ? S_DONE : S_WR_FETCH;
            end else begin
               cnt_next = cnt_reg + 32'd1;
            end
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_POWERUP;
         end
      endcase
   end

   assign bus.cmd_ready    = (state_reg == S_IDLE);
   assign bus.busy         = (state_reg != S_IDLE);
   assign bus.wr_ready     = (state_reg == S_WR_FETCH);
   assign bus.rd_valid     = (state_reg == S_RD_OUT);
   assign bus.rd_data      = rd_data_reg;
   assign bus.done         = (state_reg == S_DONE);
   assign bus.error        = error_reg;
   assign bus.m_read_req   = (state_reg == S_RD_REQ);
   assign bus.m_write_req  = (state_reg == S_WR_REQ);
   assign bus.m_dev_addr   = DEV_ADDR;
   assign bus.m_reg_addr   = addr_reg;
   assign bus.m_wdata      = wdata_reg;
   assign bus.m_addr_2byte = ADDR_2BYTE;
endmodule

// File: tb/tb_eeprom_burst_ctrl.sv
// Directed bench for eeprom_burst_ctrl with a small I2C-master responder model.
// Short power-up and write-cycle parameters keep the run brief.
module tb_eeprom_burst_ctrl;
   localparam int MAX_LEN = 8;
   localparam int PU_CYC  = 10;
   localparam int WR_CYC  = 5;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   eeprom_burst_ctrl_if #(.MAX_LEN(MAX_LEN)) bus ();

   eeprom_burst_ctrl #(
      .DEV_ADDR(8'hA0), .ADDR_2BYTE(1'b1), .MEM_BYTES(8192), .MAX_LEN(MAX_LEN),
      .POWERUP_CYCLES(PU_CYC), .WRCYC_CYCLES(WR_CYC)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Responder: acks each request on its second sampled cycle, logs it, and
   // optionally flags a NACK on one chosen request.
   logic [15:0] req_addr [64];
   logic [7:0]  req_wd   [64];
   logic        req_wr   [64];
   int          ack_cyc  [64];
   logic [7:0]  rd_tbl   [64];
   int          req_n = 0;
   int          err_on_req = -1;
   int          hold = 0;
   logic        req_prev = 1'b0;
   logic [15:0] st_addr;
   logic [7:0]  st_wdata;

   always @(negedge clk) begin
      if (!rst_n) begin
         bus.m_read_ack  = 1'b0;
         bus.m_write_ack = 1'b0;
         bus.m_error     = 1'b0;
         bus.m_rdata     = 8'h00;
         req_prev        = 1'b0;
      end else if (bus.m_read_ack || bus.m_write_ack) begin
         bus.m_read_ack  = 1'b0;
         bus.m_write_ack = 1'b0;
         bus.m_error     = 1'b0;
         req_prev        = bus.m_read_req || bus.m_write_req;
      end else begin
         if (bus.m_read_req || bus.m_write_req) begin
            if (!req_prev) begin
               st_addr  = bus.m_reg_addr;
               st_wdata = bus.m_wdata;
               hold     = 0;
               req_addr[req_n] = bus.m_reg_addr;
               req_wd[req_n]   = bus.m_wdata;
               req_wr[req_n]   = bus.m_write_req;
            end
            hold++;
            if (hold == 2) begin
               chk("req_stable", {bus.m_reg_addr, bus.m_wdata}, {st_addr, st_wdata});
               ack_cyc[req_n] = cyc;
               bus.m_error    = (req_n == err_on_req);
               bus.m_rdata    = rd_tbl[req_n];
               if (bus.m_read_req) bus.m_read_ack = 1'b1;
               else                bus.m_write_ack = 1'b1;
               if (req_n < 63) req_n++;
            end
         end
         req_prev = bus.m_read_req || bus.m_write_req;
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_busy"}, bus.busy, 1);
      chk({tag, "_ctl"}, {bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.done, bus.error,
                          bus.m_read_req, bus.m_write_req}, 0);
      chk({tag, "_data"}, {bus.rd_data, bus.m_reg_addr, bus.m_wdata}, 0);
      chk({tag, "_dev"}, {bus.m_addr_2byte, bus.m_dev_addr}, {1'b1, 8'hA0});
   endtask

   task automatic powerup_check();
      int   first = -1;
      logic stray = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (bus.m_read_req || bus.m_write_req || bus.wr_ready) stray = 1'b1;
         if (bus.cmd_ready) begin
            first = k;
            break;
         end
      end
      chk("pu_ready_cycle", first, PU_CYC);
      chk("pu_no_traffic", stray, 0);
   endtask

   task automatic issue_cmd(input logic wr, input logic [15:0] addr, input int len);
      int n = 0;
      while (n < 100) begin
         @(negedge clk);
         if (bus.cmd_ready) break;
         n++;
      end
      chk("cmd_ready_seen", n < 100, 1);
      bus.cmd_write = wr;
      bus.cmd_addr  = addr;
      bus.cmd_len   = 4'(len);
      bus.cmd_valid = 1'b1;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      $display("cmd write=%0d addr=%h len=%0d at cycle %0d", wr, addr, len, cyc);
   endtask

   task automatic wait_done(input int bound, output int seen);
      int n = 0;
      seen = -1;
      while (n < bound) begin
         @(negedge clk);
         if (bus.done) begin
            seen = cyc;
            break;
         end
         n++;
      end
      chk("done_seen", seen >= 0, 1);
      $display("done error=%0d at cycle %0d", bus.error, cyc);
   endtask

   task automatic feed_byte(input logic [7:0] d, output int seen);
      int n = 0;
      seen = -1;
      bus.wr_data  = d;
      bus.wr_valid = 1'b1;
      while (n < 50) begin
         @(negedge clk);
         if (bus.wr_ready) begin
            seen = cyc;
            break;
         end
         n++;
      end
      chk("wr_ready_seen", seen >= 0, 1);
      @(posedge clk); #1;
      bus.wr_valid = 1'b0;
      $display("wr byte %h accepted at cycle %0d", d, cyc);
   endtask

   task automatic consume_byte(input logic [7:0] exp, input int stall, input logic last);
      int n = 0;
      while (n < 50 && !bus.rd_valid) begin
         @(negedge clk);
         n++;
      end
      chk("rd_valid_seen", bus.rd_valid, 1);
      repeat (stall) @(negedge clk);
      chk("rd_hold", {bus.rd_valid, bus.rd_data}, {1'b1, exp});
      bus.rd_ready = 1'b1;
      @(posedge clk); #1;
      bus.rd_ready = 1'b0;
      $display("rd byte %h accepted at cycle %0d", bus.rd_data, cyc);
      if (last) chk("rd_done_next", bus.done, 1);
      else      chk("rd_next_req", {bus.done, bus.m_read_req}, 2'b01);
   endtask

   initial begin
      #200_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int seen;
      int s1;
      int s2;
      int s3;
      for (int i = 0; i < 64; i++) rd_tbl[i] = 8'h00;
      rst_n         = 1'b0;
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 16'h0000;
      bus.cmd_len   = 4'd0;
      bus.wr_valid  = 1'b0;
      bus.wr_data   = 8'h00;
      bus.rd_ready  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("rst");

      // Power-up with cmd_valid held (len 0): ready at cycle 10, then immediate error.
      @(negedge clk);
      rst_n = 1'b1;
      powerup_check();
      @(posedge clk); #1;
      chk("len0_done", {bus.done, bus.error, bus.cmd_ready}, 3'b110);
      bus.cmd_valid = 1'b0;
      chk("len0_no_req", req_n, 0);

      // Write of 3 bytes wrapping past the top of an 8 KiB device.
      base = req_n;
      issue_cmd(1'b1, 16'h1FFF, 3);
      feed_byte(8'hA1, s1);
      feed_byte(8'hB2, s2);
      chk("wr_gap0", s2 - ack_cyc[base], WR_CYC + 1);
      feed_byte(8'hC3, s3);
      chk("wr_gap1", s3 - ack_cyc[base + 1], WR_CYC + 1);
      wait_done(40, seen);
      chk("wr_gap_last", seen - ack_cyc[base + 2], WR_CYC + 1);
      chk("wr_err", bus.error, 0);
      chk("wr_count", req_n - base, 3);
      chk("wr_req0", {req_wr[base], req_addr[base], req_wd[base]}, {1'b1, 16'h1FFF, 8'hA1});
      chk("wr_req1", {req_wr[base+1], req_addr[base+1], req_wd[base+1]}, {1'b1, 16'h0000, 8'hB2});
      chk("wr_req2", {req_wr[base+2], req_addr[base+2], req_wd[base+2]}, {1'b1, 16'h0001, 8'hC3});

      // Read of 2 bytes with a 4-cycle consumer stall on each.
      base = req_n;
      rd_tbl[base]     = 8'h5A;
      rd_tbl[base + 1] = 8'h3C;
      issue_cmd(1'b0, 16'h0010, 2);
      chk("rd_req_latency", bus.m_read_req, 1);
      consume_byte(8'h5A, 4, 1'b0);
      consume_byte(8'h3C, 4, 1'b1);
      chk("rd_err", bus.error, 0);
      chk("rd_count", req_n - base, 2);
      chk("rd_addrs", {req_wr[base], req_addr[base], req_wr[base+1], req_addr[base+1]},
          {1'b0, 16'h0010, 1'b0, 16'h0011});

      // NACK on the second request of a 4-byte read.
      base = req_n;
      rd_tbl[base]     = 8'h11;
      rd_tbl[base + 1] = 8'h22;
      err_on_req       = base + 1;
      issue_cmd(1'b0, 16'h0100, 4);
      consume_byte(8'h11, 0, 1'b0);
      wait_done(20, seen);
      chk("nack_err", bus.error, 1);
      chk("nack_count", req_n - base, 2);
      err_on_req = -1;

      // Next accepted command clears the error.
      base = req_n;
      issue_cmd(1'b1, 16'h0005, 1);
      chk("err_cleared", bus.error, 0);
      feed_byte(8'hA5, s1);
      wait_done(40, seen);
      chk("wr1_result", {bus.error, req_addr[base], req_wd[base]}, {1'b0, 16'h0005, 8'hA5});

      // Over-length command.
      base = req_n;
      issue_cmd(1'b1, 16'h0000, MAX_LEN + 1);
      wait_done(2, seen);
      chk("len_over_err", bus.error, 1);
      chk("len_over_no_req", req_n - base, 0);

      // Asynchronous reset while waiting out the write cycle.
      issue_cmd(1'b1, 16'h0200, 2);
      feed_byte(8'h77, s1);
      for (int n = 0; n < 20 && !bus.m_write_ack; n++) @(negedge clk);
      chk("rst_ack_seen", bus.m_write_ack, 1);
      @(posedge clk); #3;
      chk("rst_pre_busy", {bus.busy, bus.m_reg_addr, bus.m_wdata}, {1'b1, 16'h0200, 8'h77});
      rst_n = 1'b0;
      #1;
      check_reset_outputs("arst");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      powerup_check();
      seen = 0;
      repeat (5) begin
         @(negedge clk);
         if (bus.wr_ready || bus.m_write_req || bus.busy) seen = 1;
      end
      chk("arst_not_resumed", seen, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
